// File: rtl/srl_pattern_checker.sv
// Stimulus generator and self-checker for a group of SRLC32E shift registers that share CE/D/A.
// Optional build macro: SRL_CHK_HALT_ON_ERR_EN, which stops the test at the first mismatching compare.
module srl_pattern_checker #(
  parameter int          NUM_CH     = 2,
  parameter int          RUN_CYCLES = 1024,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              CE,
  output logic              D,
  output logic [4:0]        A,
  input  logic [NUM_CH-1:0] Q,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [15:0]       ERR_COUNT,
  output logic [NUM_CH-1:0] ERR_MASK,
  output logic [1:0]        dbg_state
);

  // SRL-side handshake: CE/D/A are registered and change only at CLK edges. The SRLs shift on
  // the same edge as the shadow register, and Q is a combinational read of srl[A].
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] LAST_RUN = 16'(RUN_CYCLES - 1);

  state_t            state, state_d;
  logic [15:0]       lfsr, lfsr_d, lfsr_step;
  logic [4:0]        fill_cnt, fill_cnt_d;
  logic [15:0]       run_cnt, run_cnt_d;
  logic [31:0]       shadow;
  logic              ce_d, d_d;
  logic [4:0]        a_d;
  logic [NUM_CH-1:0] mismatch;
  logic              any_mis;
  logic              start_go;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting towards bit 0.
  assign lfsr_step = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign mismatch  = Q ^ {NUM_CH{shadow[A]}};
  assign any_mis   = (state == S_RUN) && (|mismatch);
  assign start_go  = START && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (START) state_d = S_FILL;
      S_FILL:         if (fill_cnt == 5'd31) state_d = S_RUN;
      S_RUN: begin
        if (run_cnt == LAST_RUN) state_d = S_DONE;
`ifdef SRL_CHK_HALT_ON_ERR_EN
        if (any_mis) state_d = S_DONE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs for the next cycle are computed from next-state values, so CE/D/A leave flops.
  always_comb begin
    lfsr_d     = lfsr;
    fill_cnt_d = fill_cnt;
    run_cnt_d  = run_cnt;
    ce_d       = 1'b0;
    d_d        = D;
    a_d        = A;
    if ((state == S_FILL) || (state == S_RUN)) lfsr_d = lfsr_step;
    if (start_go) begin
      lfsr_d     = SEED;
      fill_cnt_d = 5'd0;
      run_cnt_d  = 16'd0;
    end else if (state == S_FILL) begin
      fill_cnt_d = fill_cnt + 5'd1;
    end else if (state == S_RUN) begin
      run_cnt_d = run_cnt + 16'd1;
    end
    case (state_d)
      S_FILL: begin
        ce_d = 1'b1;
        d_d  = lfsr_d[0];
        a_d  = fill_cnt_d;
      end
      S_RUN: begin
        ce_d = lfsr_d[1];
        d_d  = lfsr_d[0];
        a_d  = lfsr_d[6:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr      <= SEED;
      fill_cnt  <= 5'd0;
      run_cnt   <= 16'd0;
      shadow    <= 32'd0;
      CE        <= 1'b0;
      D         <= 1'b0;
      A         <= 5'd0;
      ERR_COUNT <= 16'd0;
      ERR_MASK  <= '0;
    end else begin
      lfsr     <= lfsr_d;
      fill_cnt <= fill_cnt_d;
      run_cnt  <= run_cnt_d;
      CE       <= ce_d;
      D        <= d_d;
      A        <= a_d;
      if (CE) shadow <= {shadow[30:0], D};
      if (start_go) begin
        ERR_COUNT <= 16'd0;
        ERR_MASK  <= '0;
      end else if (state == S_RUN) begin
        ERR_MASK <= ERR_MASK | mismatch;
        if (any_mis && (ERR_COUNT != 16'hFFFF)) ERR_COUNT <= ERR_COUNT + 16'd1;
      end
    end
  end

  assign BUSY      = (state == S_FILL) || (state == S_RUN);
  assign DONE      = (state == S_DONE);
  assign PASS      = DONE && (ERR_COUNT == 16'd0);
  assign dbg_state = state;

endmodule

// File: tb/tb_srl_pattern_checker.sv
// Bench for srl_pattern_checker: behavioural SRLC32E pair with injectable faults, queue-based scoreboard.
module tb_srl_pattern_checker;
  localparam int          NUM_CH     = 2;
  localparam int          RUN        = 256;
  localparam logic [15:0] SEED_PARAM = 16'h0000;
  localparam logic [15:0] EFF_SEED   = 16'hACE1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic              ce, d;
  logic [4:0]        a;
  logic [NUM_CH-1:0] q;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [NUM_CH-1:0] err_mask;
  logic [1:0]        dbg_state;

  srl_pattern_checker #(.NUM_CH(NUM_CH), .RUN_CYCLES(RUN), .LFSR_SEED(SEED_PARAM)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .CE(ce), .D(d), .A(a), .Q(q),
    .BUSY(busy), .DONE(done), .PASS(pass), .ERR_COUNT(err_count), .ERR_MASK(err_mask),
    .dbg_state(dbg_state)
  );

  // behavioural SRLC32E channels: contents are never reset
  logic [31:0] srl [NUM_CH];
  int          fault_mode = 0;
  logic [4:0]  a_p1;

  always @(posedge clk)
    if (ce) for (int i = 0; i < NUM_CH; i++) srl[i] <= {srl[i][30:0], d};

  always_comb begin
    a_p1 = a + 5'd1;
    for (int i = 0; i < NUM_CH; i++) q[i] = srl[i][a];
    if (fault_mode == 1) q[1] = 1'b0;
    else if (fault_mode == 2) for (int i = 0; i < NUM_CH; i++) q[i] = srl[i][a_p1];
  end

  // scoreboard
  logic [6:0]        exp_q[$];
  int                exp_errs;
  logic [NUM_CH-1:0] exp_mask;
  logic [4:0]        exp_last_a;
  int                n_cmp  = 0;
  int                n_fail = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {CE,D,A} per busy cycle plus final error results for a given fault
  task automatic build_expected(input int fmode);
    logic [15:0]       l;
    logic [31:0]       sh;
    logic [4:0]        aa, aa1;
    logic              ce_b, d_b, s;
    logic [NUM_CH-1:0] mis;
    l = EFF_SEED;
    sh = 32'd0;
    exp_errs = 0;
    exp_mask = '0;
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      aa = 5'(k);
      exp_q.push_back({1'b1, l[0], aa});
      exp_last_a = aa;
      sh = {sh[30:0], l[0]};
      l = lfsr_next(l);
    end
    for (int r = 0; r < RUN; r++) begin
      ce_b = l[1];
      d_b  = l[0];
      aa   = l[6:2];
      exp_q.push_back({ce_b, d_b, aa});
      exp_last_a = aa;
      s   = sh[aa];
      mis = '0;
      if (fmode == 1) mis[1] = s;
      else if (fmode == 2) begin
        aa1 = aa + 5'd1;
        mis = {NUM_CH{sh[aa1] != s}};
      end
      if (mis != '0) begin
        if (exp_errs < 65535) exp_errs++;
        exp_mask |= mis;
`ifdef SRL_CHK_HALT_ON_ERR_EN
        break;
`endif
      end
      if (ce_b) sh = {sh[30:0], d_b};
      l = lfsr_next(l);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, 32'({ce, d, a, busy, done, pass, err_mask, err_count}), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // driver: one START, then pop/compare every busy cycle; optional START pulses and mid-run reset
  task automatic run_test(input int fmode, input int pulse_a, input int pulse_b, input int reset_at);
    logic [6:0] e;
    int         idx;
    bit         aborted;
    fault_mode = fmode;
    build_expected(fmode);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    aborted = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy", 32'(busy), 32'd1);
      check("ce_d_a", 32'({ce, d, a}), 32'(e));
      if (idx == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        repeat (2) @(negedge clk);
        check_reset_values("reset_held");
        rst_n = 1'b1;
        exp_q.delete();
        aborted = 1;
        break;
      end
      start = (idx == pulse_a) || (idx == pulse_b);
      @(negedge clk);
      idx++;
    end
    start = 1'b0;
    if (!aborted) begin
      check("busy_end", 32'(busy), 32'd0);
      check("done", 32'(done), 32'd1);
      check("pass", 32'(pass), 32'(exp_errs == 0));
      check("err_count", 32'(err_count), 32'(exp_errs));
      check("err_mask", 32'(err_mask), 32'(exp_mask));
      check("held_addr", 32'({ce, a}), 32'({1'b0, exp_last_a}));
      check("done_state", 32'(dbg_state), 32'd3);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) srl[i] = $urandom();
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle_after_reset");

    run_test(0, -1, -1, -1);                         // clean run
    run_test(0, 10, 32 + 50, -1);                    // START while busy is ignored
    run_test(1, -1, -1, -1);                         // channel 1 stuck at 0
    run_test(2, -1, -1, -1);                         // off-by-one address read
    run_test(0, -1, -1, 32 + 100);                   // reset mid-RUN
    run_test(0, -1, -1, -1);                         // full fresh FILL and clean pass
    run_test(0, $urandom_range(0, 31), -1, -1);      // repeat run, same sequence

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/srl_pattern_checker.md
Name: srl_pattern_checker

Overview:
- Stimulus generator and self-checker that sits directly upstream and downstream of a group of SRLC32E shift-register LUTs sharing CLK/CE/D/A.
- Drives the shared CE, D and A nets of the SRLs and consumes their Q outputs.
- Keeps a 32-bit shadow shift register and compares every channel's Q against shadow[A] each cycle.
- Used in SRL fuzzer/minitest hardware runs to confirm the placed SRLs behave as an ideal 32-deep shift register.

Parameters:
- NUM_CH, 2, number of SRL channels sharing CE/D/A (1..8).
- RUN_CYCLES, 1024, number of compare cycles per test (1..65535).
- LFSR_SEED, 16'hACE1, LFSR reload value; a value of 0 is replaced by 16'hACE1.

Ports:
- CLK  input  1  clock; the SRLs use the same clock.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request to begin a test.
- CE  output  1  shared SRL clock enable (registered).
- D  output  1  shared SRL serial data (registered).
- A  output  5  shared SRL read address (registered).
- Q  input  NUM_CH  SRL outputs; combinational read of srl[A].
- BUSY  output  1  high in FILL or RUN.
- DONE  output  1  high in DONE state.
- PASS  output  1  DONE && ERR_COUNT==0.
- ERR_COUNT  output  16  saturating count of mismatching compare cycles.
- ERR_MASK  output  NUM_CH  sticky per-channel mismatch flags.

Behaviour:
- Reset (async, RST_N=0): state IDLE; CE=0, D=0, A=0, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, ERR_MASK=0; LFSR=seed; shadow=0; counters=0.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances one step per cycle in FILL and RUN; holds otherwise.
- States:
  - IDLE: CE=0. On START go to FILL; clear ERR_COUNT and ERR_MASK; reload LFSR with seed.
  - FILL (exactly 32 cycles): CE=1; D=lfsr[0]; A=fill counter (0..31). Flushes the unknown SRL contents, which RST_N does not reset. No compares are made. Goes to RUN after the 32nd cycle.
  - RUN (exactly RUN_CYCLES cycles): CE=lfsr[1]; D=lfsr[0]; A=lfsr[6:2]. Goes to DONE after the last compare.
  - DONE: CE=0; DONE=1; results held. START re-enters FILL with results cleared and the LFSR reloaded.
- Shadow update: at every clock edge, if the registered CE==1, shadow <= {shadow[30:0], registered D}. This matches the SRL edge exactly.
- Compare: at every clock edge where the pre-edge state is RUN, mismatch[i] = Q[i] != shadow[A], using pre-edge shadow and A.
  - ERR_MASK |= mismatch.
  - If any mismatch bit is set, ERR_COUNT increments by 1 (saturates at 16'hFFFF; no wrap).
- Compare-to-result latency: 1 cycle. DONE rises on the edge after the last RUN cycle, and PASS is valid in the same cycle.
- START is ignored while BUSY.
- START and reset asserted together: reset wins.
- RST_N asserted mid-FILL or mid-RUN: immediate return to IDLE with reset values. The next START performs a full FILL again.
- RUN_CYCLES=1: exactly one compare, then DONE.
- A and D change only at clock edges. CE low in RUN means no shift, and the compare uses the unchanged shadow.

Optional Feature:
- Macro SRL_CHK_HALT_ON_ERR_EN.
- Defined:
  - The first compare cycle with any mismatch moves the block straight to DONE.
  - ERR_COUNT=1 and ERR_MASK shows the failing channels.
  - A, D and the shadow are frozen (CE=0) so the failing address can be read back.
- Undefined: the run always completes RUN_CYCLES compares.

Test Plan:
- Clean run: NUM_CH=2, RUN_CYCLES=1024, ideal behavioural SRLC32E pair attached, START pulse -> BUSY for 32+1024 cycles, then DONE=1, PASS=1, ERR_COUNT=0, ERR_MASK=2'b00.
- Stuck fault: channel 1 Q forced to 0, RUN_CYCLES=256 -> DONE=1, PASS=0, ERR_MASK=2'b10, ERR_COUNT between 1 and 256, matching the bench count of cycles where shadow[A]==1.
- Mid-run reset: pull RST_N low for 2 cycles at RUN cycle 100 -> all outputs at reset values, CE=0. A new START -> a fresh 32-cycle FILL and a clean pass.
- START while busy: pulse START at FILL cycle 10 and RUN cycle 50 -> no restart; total busy time stays 32+RUN_CYCLES.
- Off-by-one address fault: model returns srl[A+1] -> ERR_MASK=2'b11 and ERR_COUNT>0. With SRL_CHK_HALT_ON_ERR_EN defined -> DONE on the first mismatch, ERR_COUNT=1, A held at the failing address.
- Determinism: two consecutive runs with LFSR_SEED=16'h0001 -> identical CE/D/A sequences cycle-for-cycle. LFSR_SEED=0 -> same sequence as 16'hACE1.
